instr_mem_responder: RTL and testbench

Instruction-memory slave that answers the fetch stage's syn/ack/last request protocol. It samples a request address, waits a configurable number of wait-state cycles, then returns one instruction word with a one-cycle ack pulse. It flags `last` when the returned word is the final program instruction. A write port lets the testbench or program loader fill the array.

---
 rtl/instr_mem_responder_pkg.sv | 22 ++
 rtl/instr_mem_responder_if.sv | 38 +++
 rtl/instr_mem_responder_array.sv | 26 ++
 rtl/instr_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_instr_mem_responder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder: FSM encoding,
// the NOP returned on out-of-range fetches, and an index-width helper.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Fetch-side request/response bus plus the loader write port of the instruction memory.
// im_o_err only exists when IMEM_RANGE_CHECK_EN is defined.
interface instr_mem_responder_if #(
  parameter int IWIDTH       = 32,
  parameter int AWIDTH_INSTR = 32
);

  logic                    im_i_syn;
  logic [AWIDTH_INSTR-1:0] im_i_addr;
  logic [IWIDTH-1:0]       im_o_instr;
  logic                    im_o_ack;
  logic                    im_o_last;
  logic [AWIDTH_INSTR-1:0] im_i_last_addr;
  logic                    im_i_we;
  logic [AWIDTH_INSTR-1:0] im_i_waddr;
  logic [IWIDTH-1:0]       im_i_wdata;
  logic                    im_o_busy;
`ifdef IMEM_RANGE_CHECK_EN
  logic                    im_o_err;
`endif

  modport slave (
    input  im_i_syn, im_i_addr, im_i_last_addr, im_i_we, im_i_waddr, im_i_wdata,
    output im_o_instr, im_o_ack, im_o_last, im_o_busy
`ifdef IMEM_RANGE_CHECK_EN
    , output im_o_err
`endif
  );

  modport master (
    output im_i_syn, im_i_addr, im_i_last_addr, im_i_we, im_i_waddr, im_i_wdata,
    input  im_o_instr, im_o_ack, im_o_last, im_o_busy
`ifdef IMEM_RANGE_CHECK_EN
    , input im_o_err
`endif
  );

endinterface

// File: rtl/instr_mem_responder_array.sv
// DEPTH x IWIDTH instruction storage: synchronous write, combinational read by index.
// Contents are deliberately not reset so a loaded program survives a responder reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int IWIDTH = 32,
  parameter int DEPTH  = 1024,
  parameter int IDXW   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDXW-1:0]   waddr_i,
  input  logic [IWIDTH-1:0] wdata_i,
  input  logic [IDXW-1:0]   raddr_i,
  output logic [IWIDTH-1:0] rdata_o
);

  logic [IWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory slave for the fetch stage's syn/ack/last protocol with LATENCY wait states.
// Define IMEM_RANGE_CHECK_EN to answer out-of-range fetches with a NOP and a sticky im_o_err.
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter int IWIDTH       = 32,
  parameter int AWIDTH_INSTR = 32,
  parameter int DEPTH        = 1024,
  parameter int LATENCY      = 1
) (
  input  logic                  im_clk,
  input  logic                  im_rst,
  instr_mem_responder_if.slave  bus
);

  localparam int         IDXW     = clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("instr_mem_responder: LATENCY must lie in 1..15");
  end
  if (AWIDTH_INSTR <= IDXW + 2) begin : g_bad_awidth
    $error("instr_mem_responder: AWIDTH_INSTR too narrow for DEPTH");
  end

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              hit_q, hit_d;
  logic [IWIDTH-1:0] instr_q, instr_d;
  logic              ack_q, ack_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic              arr_we;
  logic [IWIDTH-1:0] rd_data;
`ifdef IMEM_RANGE_CHECK_EN
  logic              oor_q, oor_d;
  logic              err_q, err_d;
`endif

  // Byte-offset bits (and, when wrapping, the high write-address bits) carry no meaning here.
`ifdef IMEM_RANGE_CHECK_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.im_i_addr[1:0], bus.im_i_last_addr[1:0], bus.im_i_waddr[1:0]};
  assign arr_we = bus.im_i_we && !(|bus.im_i_waddr[AWIDTH_INSTR-1:IDXW+2]);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.im_i_addr[1:0], bus.im_i_last_addr[1:0],
                              bus.im_i_waddr[1:0], bus.im_i_waddr[AWIDTH_INSTR-1:IDXW+2]};
  assign arr_we = bus.im_i_we;
`endif

  imem_array #(
    .IWIDTH (IWIDTH),
    .DEPTH  (DEPTH),
    .IDXW   (IDXW)
  ) u_array (
    .clk     (im_clk),
    .we_i    (arr_we),
    .waddr_i (bus.im_i_waddr[IDXW+1:2]),
    .wdata_i (bus.im_i_wdata),
    .raddr_i (idx_q),
    .rdata_o (rd_data)
  );

  assign accept = bus.im_i_syn && (state_q == ST_IDLE || state_q == ST_RESP);

  always_ff @(posedge im_clk or negedge im_rst) begin
    if (!im_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      instr_q <= '0;
      ack_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef IMEM_RANGE_CHECK_EN
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      instr_q <= instr_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
`ifdef IMEM_RANGE_CHECK_EN
      oor_q   <= oor_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.im_i_syn) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!bus.im_i_syn)    state_d = ST_IDLE;
        else if (cnt_q == '0) state_d = ST_RESP;
      end
      ST_RESP: state_d = bus.im_i_syn ? ST_WAIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    instr_d = instr_q;
    ack_d   = 1'b0;
    last_d  = 1'b0;
    busy_d  = busy_q;
`ifdef IMEM_RANGE_CHECK_EN
    oor_d   = oor_q;
    err_d   = err_q;
`endif
    if (accept) begin
      idx_d  = bus.im_i_addr[IDXW+1:2];
      hit_d  = (bus.im_i_addr[AWIDTH_INSTR-1:2] == bus.im_i_last_addr[AWIDTH_INSTR-1:2]);
      cnt_d  = CNT_INIT;
      busy_d = 1'b1;
`ifdef IMEM_RANGE_CHECK_EN
      oor_d  = |bus.im_i_addr[AWIDTH_INSTR-1:IDXW+2];
`endif
    end else if (state_q == ST_WAIT) begin
      // A dropped syn wins over an expiring counter on the same edge.
      if (!bus.im_i_syn) begin
        busy_d = 1'b0;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        instr_d = rd_data;
        last_d  = hit_q;
`ifdef IMEM_RANGE_CHECK_EN
        if (oor_q) begin
          instr_d = IWIDTH'(NOP_INSTR);
          last_d  = 1'b1;
          err_d   = 1'b1;
        end
`endif
      end
    end
  end

  assign bus.im_o_instr = instr_q;
  assign bus.im_o_ack   = ack_q;
  assign bus.im_o_last  = last_q;
  assign bus.im_o_busy  = busy_q;
`ifdef IMEM_RANGE_CHECK_EN
  assign bus.im_o_err   = err_q;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 1 and 3, DEPTH 16) share clock, reset and loader writes.
// Expected words are queued when a request is driven and popped when the matching ack appears.
module tb_instr_mem_responder;

  localparam int IW  = 32;
  localparam int AW  = 32;
  localparam int DEP = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [31:0] mdl [DEP];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_mem_responder_if #(.IWIDTH(IW), .AWIDTH_INSTR(AW)) ifa ();
  instr_mem_responder_if #(.IWIDTH(IW), .AWIDTH_INSTR(AW)) ifb ();

  instr_mem_responder #(.IWIDTH(IW), .AWIDTH_INSTR(AW), .DEPTH(DEP), .LATENCY(1)) dut_a (
    .im_clk (clk),
    .im_rst (rst_n),
    .bus    (ifa)
  );

  instr_mem_responder #(.IWIDTH(IW), .AWIDTH_INSTR(AW), .DEPTH(DEP), .LATENCY(3)) dut_b (
    .im_clk (clk),
    .im_rst (rst_n),
    .bus    (ifb)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic last);
    exp_t e;
    e.instr = instr;
    e.last  = last;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ifa.im_o_ack) begin
      if (qa.size() == 0) chk("ack_a_unexpected", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("instr_a", ifa.im_o_instr, ea.instr);
        chk("last_a", ifa.im_o_last, ea.last);
      end
    end
    if (rst_n && ifb.im_o_ack) begin
      if (qb.size() == 0) chk("ack_b_unexpected", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("instr_b", ifb.im_o_instr, eb.instr);
        chk("last_b", ifb.im_o_last, eb.last);
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ifa.im_i_we = 1'b1; ifa.im_i_waddr = a; ifa.im_i_wdata = d;
    ifb.im_i_we = 1'b1; ifb.im_i_waddr = a; ifb.im_i_wdata = d;
    @(negedge clk);
    ifa.im_i_we = 1'b0;
    ifb.im_i_we = 1'b0;
  endtask

  task automatic wait_ack(input bit sel_b, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if ((sel_b ? ifb.im_o_ack : ifa.im_o_ack) === 1'b1) begin
        at = cyc;
        return;
      end
    end
    chk(sel_b ? "timeout_b" : "timeout_a", 0, 1);
  endtask

  task automatic req_b(input logic [31:0] a, input logic [31:0] exp_instr, input logic exp_last);
    int t;
    @(negedge clk);
    ifb.im_i_syn = 1'b1;
    ifb.im_i_addr = a;
    qb.push_back(mk(exp_instr, exp_last));
    wait_ack(1'b1, 20, t);
    ifb.im_i_syn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, prev;
    logic [31:0] y, z;
    ifa.im_i_syn = 1'b0; ifa.im_i_addr = '0; ifa.im_i_last_addr = 32'h0C;
    ifa.im_i_we = 1'b0;  ifa.im_i_waddr = '0; ifa.im_i_wdata = '0;
    ifb.im_i_syn = 1'b0; ifb.im_i_addr = '0; ifb.im_i_last_addr = 32'h0C;
    ifb.im_i_we = 1'b0;  ifb.im_i_waddr = '0; ifb.im_i_wdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ack_a", ifa.im_o_ack, 0);
    chk("rst_last_a", ifa.im_o_last, 0);
    chk("rst_busy_a", ifa.im_o_busy, 0);
    chk("rst_instr_a", ifa.im_o_instr, 0);
    chk("rst_ack_b", ifb.im_o_ack, 0);
    chk("rst_busy_b", ifb.im_o_busy, 0);
    chk("rst_instr_b", ifb.im_o_instr, 0);
`ifdef IMEM_RANGE_CHECK_EN
    chk("rst_err_b", ifb.im_o_err, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEP; i++) begin
      mdl[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
      wr(32'(i) * 4, mdl[i]);
    end

    // LATENCY=1 streaming fetch of words 0..3, last only with word 3
    @(negedge clk);
    ifa.im_i_syn = 1'b1;
    ifa.im_i_addr = 32'h0;
    qa.push_back(mk(mdl[0], 1'b0));
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'b0, 20, t);
      if (i > 0) chk("spacing_a", 64'(t - prev), 2);
      prev = t;
      if (i < 3) begin
        ifa.im_i_addr = 32'(i + 1) * 4;
        qa.push_back(mk(mdl[i + 1], (i + 1) == 3));
      end else begin
        ifa.im_i_syn = 1'b0;
      end
    end
    @(negedge clk);
    chk("hold_instr_a", ifa.im_o_instr, mdl[3]);
    chk("ack_drop_a", ifa.im_o_ack, 0);

    // LATENCY=3: busy for three cycles, then one ack cycle with mem[2]
    @(negedge clk);
    ifb.im_i_syn = 1'b1;
    ifb.im_i_addr = 32'h8;
    qb.push_back(mk(mdl[2], 1'b0));
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("lat3_busy", ifb.im_o_busy, (j < 3));
      chk("lat3_ack", ifb.im_o_ack, (j == 3));
    end
    ifb.im_i_syn = 1'b0;

    // Abort one cycle after acceptance
    @(negedge clk);
    ifb.im_i_syn = 1'b1;
    ifb.im_i_addr = 32'h4;
    @(negedge clk);
    chk("abort_busy_before", ifb.im_o_busy, 1);
    ifb.im_i_syn = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("abort_ack", ifb.im_o_ack, 0);
      chk("abort_busy", ifb.im_o_busy, 0);
    end
    req_b(32'h4, mdl[1], 1'b0);

    // Write on the response edge of a read to the same word returns the old word
    y = 32'hFEED_0005;
    @(negedge clk);
    ifb.im_i_syn = 1'b1;
    ifb.im_i_addr = 32'h14;
    qb.push_back(mk(mdl[5], 1'b0));
    repeat (3) @(negedge clk);
    ifa.im_i_we = 1'b1; ifa.im_i_waddr = 32'h14; ifa.im_i_wdata = y;
    ifb.im_i_we = 1'b1; ifb.im_i_waddr = 32'h14; ifb.im_i_wdata = y;
    @(negedge clk);
    chk("coll_ack", ifb.im_o_ack, 1);
    ifa.im_i_we = 1'b0;
    ifb.im_i_we = 1'b0;
    ifb.im_i_syn = 1'b0;
    mdl[5] = y;
    req_b(32'h14, y, 1'b0);

    // Address beyond DEPTH*4
    z = 32'h5A5A_A5A5;
`ifdef IMEM_RANGE_CHECK_EN
    req_b(32'h40, NOP, 1'b1);
    @(negedge clk);
    chk("err_set", ifb.im_o_err, 1);
    req_b(32'h4, mdl[1], 1'b0);
    @(negedge clk);
    chk("err_sticky", ifb.im_o_err, 1);
    wr(32'h40, z);
    req_b(32'h0, mdl[0], 1'b0);
`else
    req_b(32'h40, mdl[0], 1'b0);
    wr(32'h44, z);
    mdl[1] = z;
    req_b(32'h4, z, 1'b0);
`endif

    // Asynchronous reset in the middle of a wait
    @(negedge clk);
    ifb.im_i_syn = 1'b1;
    ifb.im_i_addr = 32'h8;
    @(negedge clk);
    chk("midwait_busy", ifb.im_o_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", ifb.im_o_ack, 0);
    chk("arst_last", ifb.im_o_last, 0);
    chk("arst_busy", ifb.im_o_busy, 0);
    chk("arst_instr_b", ifb.im_o_instr, 0);
    chk("arst_instr_a", ifa.im_o_instr, 0);
`ifdef IMEM_RANGE_CHECK_EN
    chk("arst_err", ifb.im_o_err, 0);
`endif
    ifb.im_i_syn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_b(32'h8, mdl[2], 1'b0);
    @(negedge clk);
    ifa.im_i_syn = 1'b1;
    ifa.im_i_addr = 32'h0C;
    qa.push_back(mk(mdl[3], 1'b1));
    wait_ack(1'b0, 20, t);
    ifa.im_i_syn = 1'b0;

    repeat (4) @(negedge clk);
    chk("qa_drained", 64'(qa.size()), 0);
    chk("qb_drained", 64'(qb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
